data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
Memory-side responder for the processor's data-memory port. It accepts one load/store request at a time over a valid/ready handshake, inserts a programmable number of wait states, then performs the access and returns a response over a second valid/ready handshake. It replaces the zero-latency data memory in the multi-cycle and pipelined cores. It also gives the core's stall logic a realistic slave for exercising memory latency.

Parameters:
DEPTH, 64, number of 32-bit words stored; valid byte addresses are BASE_ADDR to BASE_ADDR+4*DEPTH-4.
BASE_ADDR, 32'h0000_0000, byte address of word 0.
WAIT_CYCLES, 2, wait states inserted between request acceptance and the access (legal range 0..15).

Ports:
clock  input  1  rising-edge clock.
reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clock.
req_valid  input  1  processor presents a request.
req_ready  output  1  responder can accept a request this cycle.
req_write  input  1  1 = store, 0 = load.
req_addr  input  32  byte address.
req_wdata  input  32  store data.
resp_valid  output  1  response available.
resp_ready  input  1  processor consumes the response this cycle.
resp_rdata  output  32  load data; 0 for stores and errors.
resp_error  output  1  misaligned or out-of-range access.
busy  output  1  a transaction is outstanding (state is not IDLE).

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state goes to IDLE.
  - All memory words are cleared to 0.
  - resp_valid=0, resp_rdata=0, resp_error=0, busy=0.
  - req_ready=0 while reset_n=0 and 1 from the first cycle after reset is released.
- Reset mid-transaction: the transaction is abandoned with no response. A store not yet committed is never written.
- FSM states:
  - IDLE: req_ready=1, busy=0.
    - On the edge where req_valid=1, capture req_write, req_addr and req_wdata.
    - Load the wait counter with WAIT_CYCLES.
    - Go to WAIT if WAIT_CYCLES>0, otherwise go to ACCESS.
  - WAIT: req_ready=0, busy=1.
    - The counter decrements each cycle.
    - When the counter reaches 1 (i.e. after WAIT_CYCLES cycles in WAIT), go to ACCESS.
  - ACCESS: one cycle, req_ready=0, busy=1. At the edge leaving ACCESS:
    - a legal store writes the captured wdata into memory;
    - a legal load registers the memory word into resp_rdata;
    - resp_error is registered;
    - resp_valid is set to 1;
    - state goes to RESP.
  - RESP: resp_valid=1, busy=1, req_ready=0.
    - resp_rdata and resp_error are held stable until the edge where resp_ready=1.
    - At that edge: resp_valid→0, resp_rdata→0, resp_error→0, state→IDLE.
- Latency: a request accepted at edge N produces resp_valid=1 after edge N+WAIT_CYCLES+1. A new request can be accepted no earlier than one cycle after the response handshake.
- Only one request is outstanding at a time. Request inputs are ignored outside IDLE.
- Address decode:
  - offset = req_addr − BASE_ADDR, 32-bit unsigned.
  - Error if req_addr[1:0] != 0, or req_addr < BASE_ADDR, or offset[31:2] >= DEPTH.
  - Word index = offset[31:2].
- Error response: resp_error=1, resp_rdata=0, memory unchanged. This applies to both loads and stores.
- Store response: resp_rdata=0, resp_error=0 for a legal store.
- A load from an address written by the immediately preceding store returns the new data.
- resp_ready asserted while resp_valid=0 has no effect.

Test Plan:
1. WAIT_CYCLES=2: store addr 0x10, data 0xDEADBEEF accepted at edge N → resp_valid rises after edge N+3, resp_error=0, resp_rdata=0. A following load of 0x10 returns 0xDEADBEEF.
2. Load of 0x12 (misaligned) and a store of 0x100 (DEPTH=64, last legal address 0xFC) → resp_error=1, resp_rdata=0. A subsequent load of 0xFC still returns its prior value, 0 after reset.
3. Back-pressure: hold resp_ready=0 for 5 cycles after a load of 0x10 → resp_valid stays 1 and resp_rdata stays 0xDEADBEEF. req_ready stays 0 and a req_valid pulse in this window is ignored. Response completes on the first cycle resp_ready=1.
4. WAIT_CYCLES=0: back-to-back store 0x4←0x1234_5678 then load 0x4 with resp_ready tied 1 → each response arrives one cycle after acceptance. Load returns 0x1234_5678. req_ready is 1 again in the cycle after each handshake.
5. Reset mid-operation: store 0x8←0xCAFEF00D, assert reset_n=0 during WAIT → no response. After release, busy=0, req_ready=1, and a load of 0x8 returns 0 with resp_error=0.
6. BASE_ADDR=0x1000_0000: load 0x0FFF_FFFC → resp_error=1. Store/load of 0x1000_0000 round-trips 0xA5A5_5A5A with resp_error=0.

Source files
------------

// File: rtl/data_memory_responder.sv
// Purpose: single-outstanding load/store responder backed by a word-addressed register array.
// Latency: request accepted at edge N -> resp_valid high after edge N+WAIT_CYCLES+1.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready handshake.
module data_memory_responder #(
  parameter int          DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // BASE_ADDR is expected to be word aligned, so only its word part matters.
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_error_q;
  logic [31:0] mem_q [DEPTH];

  // Decode of the captured request; only consumed in ACCESS.
  logic [29:0]      acc_word;
  logic [IDX_W-1:0] acc_idx;
  logic             acc_err;

  // Word offset from the base, error on misalignment, underflow or overrun.
  always_comb begin
    acc_word = addr_q[31:2] - BASE_WORD;
    acc_idx  = acc_word[IDX_W-1:0];
    acc_err  = (addr_q[1:0] != 2'b00) ||
               (addr_q < BASE_ADDR) ||
               ({2'b00, acc_word} >= 32'(DEPTH));
  end

  // Request/response sequencing; response outputs are registered here.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_error_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= WAIT_INIT;
            state_q <= (WAIT_INIT == 4'd0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          // Counter runs WAIT_CYCLES..1; the cycle showing 1 is the last wait state.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          resp_valid_q <= 1'b1;
          resp_error_q <= acc_err;
          resp_rdata_q <= (!acc_err && !write_q) ? mem_q[acc_idx] : 32'd0;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_error_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Storage array: cleared by reset, written only by a legal store in ACCESS.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (state_q == S_ACCESS && write_q && !acc_err) begin
      mem_q[acc_idx] <= wdata_q;
    end
  end

  // Ready is forced low while reset is held so nothing is accepted during reset.
  assign req_ready  = reset_n && (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n      [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_error [3];
  logic        busy       [3];

  // dut0: WAIT=2 BASE=0, dut1: WAIT=0 BASE=0, dut2: WAIT=1 BASE=0x1000_0000
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int          WC = (g == 0) ? 2 : ((g == 1) ? 0 : 1);
    localparam logic [31:0] BA = (g == 2) ? 32'h1000_0000 : 32'h0000_0000;
    data_memory_responder #(.DEPTH(64), .BASE_ADDR(BA), .WAIT_CYCLES(WC)) u_dut (
      .clock      (clk),
      .reset_n    (rst_n[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_error (resp_error[g]),
      .busy       (busy[g])
    );
  end

  function automatic int wc(int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 1);
  endfunction

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   seen [3] = '{0, 0, 0};

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every presented response against the head of the scoreboard.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (resp_valid[d] === 1'b1) begin
        if (sbq.size() == 0 || sbq[0].id != d) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_resp dut%0d: rdata %h error %b, no response expected",
                   d, resp_rdata[d], resp_error[d]);
        end else begin
          if (!seen[d]) begin
            seen[d] = 1'b1;
            check("resp_latency_cycle", 32'(cyc), 32'(sbq[0].due));
          end
          check("resp_rdata", resp_rdata[d], sbq[0].rdata);
          check("resp_error", 32'(resp_error[d]), 32'(sbq[0].err));
          if (resp_ready[d] === 1'b1) begin
            void'(sbq.pop_front());
            seen[d] = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request (called just after a rising edge); returns the accept edge index.
  task automatic issue(int d, logic wr, logic [31:0] addr, logic [31:0] wd,
                       logic [31:0] er, logic ee, bit push, output int acc);
    int   n;
    exp_t e;
    n = 0;
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    @(negedge clk);
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = cyc + 1;
    if (n >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL req_accept_timeout dut%0d: req_ready %b, expected 1", d, req_ready[d]);
    end else if (push) begin
      e.id = d; e.rdata = er; e.err = ee; e.due = acc + wc(d) + 1;
      sbq.push_back(e);
    end
    tick();
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_done(int d);
    int n;
    n = 0;
    @(negedge clk);
    while ((sbq.size() != 0 || resp_valid[d] !== 1'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL resp_timeout dut%0d: %0d responses outstanding, expected 0", d, sbq.size());
    end
    check("idle_rdata", resp_rdata[d], 32'd0);
    check("idle_error", 32'(resp_error[d]), 32'd0);
    check("idle_busy", 32'(busy[d]), 32'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, n;
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_write[d] = 1'b0;
      req_addr[d] = 32'd0; req_wdata[d] = 32'd0; resp_ready[d] = 1'b1;
    end
    repeat (3) tick();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_req_ready", 32'(req_ready[d]), 32'd0);
      check("rst_busy", 32'(busy[d]), 32'd0);
      check("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
      check("rst_resp_rdata", resp_rdata[d], 32'd0);
      check("rst_resp_error", 32'(resp_error[d]), 32'd0);
    end
    tick();
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check("post_rst_req_ready", 32'(req_ready[d]), 32'd1);
    tick();

    // Store then load round trip with two wait states.
    issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1, a0);
    wait_done(0);
    issue(0, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, a0);
    wait_done(0);

    // Error cases leave memory untouched.
    issue(0, 1'b0, 32'h12, 32'd0, 32'd0, 1'b1, 1'b1, a0);
    wait_done(0);
    issue(0, 1'b1, 32'h100, 32'h5555_5555, 32'd0, 1'b1, 1'b1, a0);
    wait_done(0);
    issue(0, 1'b1, 32'h13, 32'h7777_7777, 32'd0, 1'b1, 1'b1, a0);
    wait_done(0);
    issue(0, 1'b0, 32'hFC, 32'd0, 32'd0, 1'b0, 1'b1, a0);
    wait_done(0);
    issue(0, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, a0);
    wait_done(0);

    // Backpressure: response held, ready low, stray request ignored.
    resp_ready[0] = 1'b0;
    issue(0, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, a0);
    n = 0;
    @(negedge clk);
    while (resp_valid[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_resp_valid_rise", 32'(resp_valid[0]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_req_ready", 32'(req_ready[0]), 32'd0);
      check("bp_resp_valid", 32'(resp_valid[0]), 32'd1);
      tick();
      req_valid[0] = (k == 1);
      req_write[0] = 1'b1;
      req_addr[0]  = 32'h10;
      req_wdata[0] = 32'h0BAD_0BAD;
    end
    req_valid[0] = 1'b0;
    resp_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_valid_before_hs", 32'(resp_valid[0]), 32'd1);
    tick();
    @(negedge clk);
    check("bp_valid_after_hs", 32'(resp_valid[0]), 32'd0);
    tick();
    issue(0, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, a0);
    wait_done(0);

    // Reset during WAIT abandons the store.
    issue(0, 1'b1, 32'h8, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0, a0);
    rst_n[0] = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", 32'(req_ready[0]), 32'd0);
    tick();
    rst_n[0] = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy[0]), 32'd0);
    check("midrst_req_ready_after", 32'(req_ready[0]), 32'd1);
    check("midrst_resp_valid", 32'(resp_valid[0]), 32'd0);
    tick();
    repeat (4) tick();
    issue(0, 1'b0, 32'h8, 32'd0, 32'd0, 1'b0, 1'b1, a0);
    wait_done(0);
    issue(0, 1'b0, 32'h10, 32'd0, 32'd0, 1'b0, 1'b1, a0);
    wait_done(0);

    // Zero wait states, back-to-back store/load.
    issue(1, 1'b1, 32'h4, 32'h1234_5678, 32'd0, 1'b0, 1'b1, a0);
    issue(1, 1'b0, 32'h4, 32'd0, 32'h1234_5678, 1'b0, 1'b1, a1);
    check("b2b_accept_gap", 32'(a1 - a0), 32'd3);
    wait_done(1);

    // Non-zero base address.
    issue(2, 1'b0, 32'h0FFF_FFFC, 32'd0, 32'd0, 1'b1, 1'b1, a0);
    wait_done(2);
    issue(2, 1'b1, 32'h1000_0000, 32'hA5A5_5A5A, 32'd0, 1'b0, 1'b1, a0);
    wait_done(2);
    issue(2, 1'b0, 32'h1000_0000, 32'd0, 32'hA5A5_5A5A, 1'b0, 1'b1, a0);
    wait_done(2);
    issue(2, 1'b0, 32'h1000_00FC, 32'd0, 32'd0, 1'b0, 1'b1, a0);
    wait_done(2);
    issue(2, 1'b0, 32'h1000_0100, 32'd0, 32'd0, 1'b1, 1'b1, a0);
    wait_done(2);

    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
